// File: rtl/ram_block_mover.sv
// Block copy / fill engine driving a single-port synchronous RAM.
// Copy alternates a read cycle and a write cycle per word. Fill writes one word per cycle.
// Every output except ram_wDat comes straight from a flop.
module ram_block_mover #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] pattern,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_addr,
  output logic          ram_wEn,
  output logic [DW-1:0] ram_wDat,
  output logic          ram_rEn,
  input  logic [DW-1:0] ram_rDat
);

  typedef enum logic [2:0] {StIdle, StRd, StWr, StFill, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] src_ptr_q, src_ptr_d;
  logic [AW-1:0] dst_ptr_q, dst_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] pat_q, pat_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          wen_q, wen_d;
  logic          ren_q, ren_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdat_q, wdat_d;

  // Next state, pointer updates, and the output values the next state will present.
  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_ptr_d = src_addr;
          dst_ptr_d = dst_addr;
          cnt_d     = len;
          pat_d     = pattern;
          if (len == '0) state_d = StDone;
          else           state_d = mode ? StFill : StRd;
        end
      end
      StRd: begin
        src_ptr_d = src_ptr_q + AW'(1);
        state_d   = abort ? StIdle : StWr;
      end
      StWr: begin
        dst_ptr_d = dst_ptr_q + AW'(1);
        cnt_d     = cnt_q - (AW+1)'(1);
        if (abort)                        state_d = StIdle;
        else if (cnt_q == (AW+1)'(1))     state_d = StDone;
        else                              state_d = StRd;
      end
      StFill: begin
        dst_ptr_d = dst_ptr_q + AW'(1);
        cnt_d     = cnt_q - (AW+1)'(1);
        if (abort)                        state_d = StIdle;
        else if (cnt_q == (AW+1)'(1))     state_d = StDone;
        else                              state_d = StFill;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are precomputed here so they leave the block registered (Moore).
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
    ren_d  = (state_d == StRd);
    wen_d  = (state_d == StWr) || (state_d == StFill);
    if (state_d == StRd)  addr_d = src_ptr_d;
    else if (wen_d)       addr_d = dst_ptr_d;
    else                  addr_d = '0;
    wdat_d = (state_d == StFill) ? pat_d : '0;
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      cnt_q     <= '0;
      pat_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      addr_q    <= '0;
      wdat_q    <= '0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
    end
  end

  // Copy write data is the RAM read data of the previous cycle, passed through unregistered.
  always_comb begin
    busy     = busy_q;
    done     = done_q;
    ram_wEn  = wen_q;
    ram_rEn  = ren_q;
    ram_addr = addr_q;
    ram_wDat = (state_q == StWr) ? ram_rDat : wdat_q;
  end

endmodule

// File: tb/tb_ram_block_mover.sv
// Directed bench for ram_block_mover with a behavioural 512x32 synchronous RAM.
module tb_ram_block_mover;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, mode, abort;
  logic [8:0]  src_addr, dst_addr;
  logic [9:0]  len;
  logic [31:0] pattern;
  logic        busy, done, ram_wEn, ram_rEn;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wDat, ram_rDat;

  logic [31:0] mem [512];
  logic [31:0] rdat_q = '0;
  logic        bd_we = 1'b0;
  logic [8:0]  bd_addr = '0;
  logic [31:0] bd_dat = '0;
  logic        clr_log = 1'b0;
  int          wr_cnt = 0, rd_cnt = 0, done_cnt = 0, both_cnt = 0;
  logic [8:0]  wr_addr_log [16];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  ram_block_mover #(.AW(9), .DW(32)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .mode     (mode),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .pattern  (pattern),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .ram_addr (ram_addr),
    .ram_wEn  (ram_wEn),
    .ram_wDat (ram_wDat),
    .ram_rEn  (ram_rEn),
    .ram_rDat (ram_rDat)
  );

  assign ram_rDat = rdat_q;

  // RAM model plus bus activity log; the backdoor port preloads words between operations.
  always @(posedge clock) begin
    if (clr_log) begin
      wr_cnt   <= 0;
      rd_cnt   <= 0;
      done_cnt <= 0;
    end else begin
      if (ram_wEn) begin
        wr_addr_log[wr_cnt[3:0]] <= ram_addr;
        wr_cnt <= wr_cnt + 1;
      end
      if (ram_rEn) rd_cnt <= rd_cnt + 1;
      if (done)    done_cnt <= done_cnt + 1;
    end
    if (ram_wEn && ram_rEn) both_cnt <= both_cnt + 1;
    if (bd_we)        mem[bd_addr] <= bd_dat;
    else if (ram_wEn) mem[ram_addr] <= ram_wDat;
    if (ram_rEn) rdat_q <= mem[ram_addr];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bd_write(input logic [8:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_dat = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic clear_log();
    clr_log = 1'b1;
    tick();
    clr_log = 1'b0;
  endtask

  // Present a command for one edge; returns in cycle 1 after the accepting edge.
  task automatic issue(input logic m, input logic [8:0] s, input logic [8:0] d,
                       input logic [9:0] l, input logic [31:0] p);
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; pattern = p;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; pattern = '0;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_wen", ram_wEn, 0);
    check_eq("rst_ren", ram_rEn, 0);
    check_eq("rst_addr", ram_addr, 0);
    check_eq("rst_wdat", ram_wDat, 0);
    ticks(2);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) bd_write(9'h010 + 9'(i), 32'(i + 1));
    bd_write(9'h050, 32'h0000_CAFE);
    bd_write(9'h183, 32'h0000_0BAD);
    clear_log();

    // Copy 4 words 0x010 -> 0x100
    issue(1'b0, 9'h010, 9'h100, 10'd4, 32'h0);
    check_eq("cp_c1_ren", ram_rEn, 1);
    check_eq("cp_c1_addr", ram_addr, 9'h010);
    check_eq("cp_c1_busy", busy, 1);
    tick();
    check_eq("cp_c2_wen", ram_wEn, 1);
    check_eq("cp_c2_addr", ram_addr, 9'h100);
    check_eq("cp_c2_wdat", ram_wDat, 32'd1);
    ticks(6);
    check_eq("cp_c8_done_low", done, 0);
    tick();
    check_eq("cp_c9_done", done, 1);
    check_eq("cp_c9_busy", busy, 1);
    tick();
    check_eq("cp_c10_busy", busy, 0);
    check_eq("cp_c10_done", done, 0);
    for (int i = 0; i < 4; i++) check_eq("cp_mem", mem[9'h100 + 9'(i)], 32'(i + 1));
    check_eq("cp_wr_cnt", wr_cnt, 4);
    check_eq("cp_rd_cnt", rd_cnt, 4);
    check_eq("cp_done_cnt", done_cnt, 1);
    clear_log();

    // Fill 3 words at 0x1FE with wrap
    issue(1'b1, 9'h000, 9'h1FE, 10'd3, 32'hDEAD_BEEF);
    check_eq("fl_c1_wen", ram_wEn, 1);
    check_eq("fl_c1_addr", ram_addr, 9'h1FE);
    check_eq("fl_c1_wdat", ram_wDat, 32'hDEAD_BEEF);
    ticks(3);
    check_eq("fl_c4_done", done, 1);
    tick();
    check_eq("fl_wr_cnt", wr_cnt, 3);
    check_eq("fl_rd_cnt", rd_cnt, 0);
    check_eq("fl_addr0", wr_addr_log[0], 9'h1FE);
    check_eq("fl_addr1", wr_addr_log[1], 9'h1FF);
    check_eq("fl_addr2", wr_addr_log[2], 9'h000);
    check_eq("fl_mem_wrap", mem[0], 32'hDEAD_BEEF);
    clear_log();

    // Zero length, both modes
    issue(1'b0, 9'h010, 9'h100, 10'd0, 32'h0);
    check_eq("z0_c1_done", done, 1);
    check_eq("z0_c1_wen", ram_wEn, 0);
    tick();
    issue(1'b1, 9'h010, 9'h100, 10'd0, 32'h1234);
    check_eq("z1_c1_done", done, 1);
    tick();
    check_eq("z_wr_cnt", wr_cnt, 0);
    check_eq("z_rd_cnt", rd_cnt, 0);
    check_eq("z_done_cnt", done_cnt, 2);
    clear_log();

    // Start while busy is ignored
    issue(1'b1, 9'h000, 9'h020, 10'd8, 32'h55);
    tick();
    issue(1'b0, 9'h010, 9'h050, 10'd2, 32'hFFFF);
    ticks(6);
    check_eq("sb_c9_done", done, 1);
    ticks(5);
    check_eq("sb_wr_cnt", wr_cnt, 8);
    check_eq("sb_rd_cnt", rd_cnt, 0);
    check_eq("sb_done_cnt", done_cnt, 1);
    check_eq("sb_last_addr", wr_addr_log[7], 9'h027);
    check_eq("sb_mem_last", mem[9'h027], 32'h55);
    check_eq("sb_mem_50", mem[9'h050], 32'h0000_CAFE);
    clear_log();

    // Abort during the third write of a 6-word copy
    issue(1'b0, 9'h010, 9'h180, 10'd6, 32'h0);
    ticks(5);
    check_eq("ab_c6_wen", ram_wEn, 1);
    check_eq("ab_c6_wdat", ram_wDat, 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("ab_c7_busy", busy, 0);
    check_eq("ab_c7_ren", ram_rEn, 0);
    ticks(4);
    check_eq("ab_wr_cnt", wr_cnt, 3);
    check_eq("ab_rd_cnt", rd_cnt, 3);
    check_eq("ab_done_cnt", done_cnt, 0);
    check_eq("ab_mem_182", mem[9'h182], 32'd3);
    check_eq("ab_mem_183", mem[9'h183], 32'h0000_0BAD);
    clear_log();

    // Asynchronous reset in the middle of a fill
    issue(1'b1, 9'h000, 9'h0C0, 10'd8, 32'h77);
    ticks(2);
    check_eq("rm_c3_wen", ram_wEn, 1);
    check_eq("rm_c3_addr", ram_addr, 9'h0C2);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rm_busy", busy, 0);
    check_eq("rm_wen", ram_wEn, 0);
    check_eq("rm_addr", ram_addr, 0);
    tick();
    reset_n = 1'b1;
    ticks(3);
    check_eq("rm_idle_busy", busy, 0);
    check_eq("rm_wr_cnt", wr_cnt, 2);
    issue(1'b1, 9'h000, 9'h0D0, 10'd1, 32'h99);
    check_eq("rm_new_wen", ram_wEn, 1);
    check_eq("rm_new_addr", ram_addr, 9'h0D0);
    tick();
    check_eq("rm_new_done", done, 1);
    tick();
    check_eq("rm_new_mem", mem[9'h0D0], 32'h99);

    check_eq("never_wen_and_ren", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
